// File: rtl/uart_challenge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_challenge_ctrl
// Brief    : Frames UART challenge bytes, launches the core, streams response.
// Revision : 1.0
// ============================================================================
module uart_challenge_ctrl #(
    parameter int         CHALLENGE_BITS = 32,
    parameter int         RESPONSE_BITS  = 16,
    parameter logic [7:0] HEADER_BYTE    = 8'hA5,
    parameter int         BYTE_TIMEOUT   = 20000,
    parameter int         CORE_TIMEOUT   = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_data_valid,
    output logic [CHALLENGE_BITS-1:0] core_challenge,
    output logic                      core_start,
    input  logic                      core_done,
    input  logic [RESPONSE_BITS-1:0]  core_response,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic                      busy,
    output logic [7:0]                err_count
);
    localparam int c_CH_BYTES  = CHALLENGE_BITS / 8;
    localparam int c_RSP_BYTES = RESPONSE_BITS / 8;
    localparam int c_CNT_W     = $clog2(c_CH_BYTES + 1);
    localparam int c_LEFT_W    = $clog2(c_RSP_BYTES + 1);
    localparam logic [c_CNT_W-1:0]  c_LAST_BYTE = c_CNT_W'(c_CH_BYTES - 1);
    localparam logic [c_LEFT_W-1:0] c_RSP_LOAD  = c_LEFT_W'(c_RSP_BYTES);
    // A timeout fires on the TIMEOUT-th cycle spent waiting (timer starts at 0).
    localparam logic [16:0] c_BYTE_LIMIT = 17'(BYTE_TIMEOUT - 1);
    localparam logic [16:0] c_CORE_LIMIT = 17'(CORE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_SEND  = 3'd4
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic                        r_rx_valid_d;
    logic [16:0]                 r_timer;
    logic [c_CNT_W-1:0]          r_byte_cnt;
    logic [CHALLENGE_BITS-1:0]   r_chal;
    logic [CHALLENGE_BITS-1:0]   r_core_chal;
    logic [RESPONSE_BITS-1:0]    r_resp;
    logic [c_LEFT_W-1:0]         r_tx_left;
    logic [7:0]                  r_err;

    logic                        w_rx_edge;
    logic                        w_last_byte;
    logic                        w_byte_to;
    logic                        w_core_to;
    logic                        w_tx_fire;
    logic                        w_err_inc;
    logic [CHALLENGE_BITS-1:0]   w_chal_shift;

    assign w_rx_edge    = rx_data_valid && !r_rx_valid_d;
    assign w_last_byte  = (r_byte_cnt == c_LAST_BYTE);
    assign w_byte_to    = (r_timer == c_BYTE_LIMIT);
    assign w_core_to    = (r_timer == c_CORE_LIMIT);
    assign w_tx_fire    = (r_state == S_SEND) && tx_ready;
    assign w_chal_shift = (r_chal << 8) | CHALLENGE_BITS'(rx_data);

    assign core_challenge = r_core_chal;
    assign core_start     = (r_state == S_ISSUE);
    assign tx_valid       = (r_state == S_SEND);
    assign tx_data        = r_resp[RESPONSE_BITS-1 -: 8];
    assign busy           = (r_state != S_IDLE);
    assign err_count      = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A received byte takes priority over a coincident byte timeout, and
    // core_done over a coincident core timeout.
    always_comb begin
        w_state_next = r_state;
        w_err_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rx_edge && (rx_data == HEADER_BYTE)) begin
                    w_state_next = S_RECV;
                end
            end
            S_RECV: begin
                if (w_rx_edge) begin
                    if (w_last_byte) begin
                        w_state_next = S_ISSUE;
                    end
                end else if (w_byte_to) begin
                    w_state_next = S_IDLE;
                    w_err_inc    = 1'b1;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    w_state_next = S_SEND;
                end else if (w_core_to) begin
                    w_state_next = S_IDLE;
                    w_err_inc    = 1'b1;
                end
            end
            S_SEND: begin
                if (tx_ready && (r_tx_left == c_LEFT_W'(1))) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_valid_d <= 1'b0;
            r_timer      <= '0;
            r_byte_cnt   <= '0;
            r_chal       <= '0;
            r_core_chal  <= '0;
            r_resp       <= '0;
            r_tx_left    <= '0;
            r_err        <= '0;
        end else begin
            r_rx_valid_d <= rx_data_valid;

            if ((w_state_next != r_state) || ((r_state == S_RECV) && w_rx_edge)) begin
                r_timer <= '0;
            end else if ((r_state == S_RECV) || (r_state == S_WAIT)) begin
                r_timer <= r_timer + 17'd1;
            end

            if (r_state == S_IDLE) begin
                r_byte_cnt <= '0;
            end else if ((r_state == S_RECV) && w_rx_edge) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
                r_chal     <= w_chal_shift;
                // Only a complete challenge is ever presented to the core.
                if (w_last_byte) begin
                    r_core_chal <= w_chal_shift;
                end
            end

            if ((r_state == S_WAIT) && core_done) begin
                r_resp    <= core_response;
                r_tx_left <= c_RSP_LOAD;
            end else if (w_tx_fire) begin
                r_resp    <= r_resp << 8;
                r_tx_left <= r_tx_left - 1'b1;
            end

            if (w_err_inc && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_challenge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_challenge_ctrl
// Brief    : Directed, table-driven bench for uart_challenge_ctrl.
// Revision : 1.0
// ============================================================================
module tb_uart_challenge_ctrl;
    localparam int c_BTO = 40;
    localparam int c_CTO = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_data_valid;
    logic [31:0] core_challenge;
    logic        core_start;
    logic        core_done;
    logic [15:0] core_response;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  err_count;

    uart_challenge_ctrl #(
        .CHALLENGE_BITS (32),
        .RESPONSE_BITS  (16),
        .HEADER_BYTE    (8'hA5),
        .BYTE_TIMEOUT   (c_BTO),
        .CORE_TIMEOUT   (c_CTO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_data_valid  (rx_data_valid),
        .core_challenge (core_challenge),
        .core_start     (core_start),
        .core_done      (core_done),
        .core_response  (core_response),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .busy           (busy),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc_n = 0;
    int         start_cnt = 0;
    int         start_cyc = 0;
    int         edge_cyc = 0;
    int         exp_err = 0;
    logic [7:0] tx_q[$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (core_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc_n;
        end
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    end

    typedef struct {
        logic [31:0] bytes;
        int          hold;
        int          done_delay;
        logic [15:0] resp;
        logic [31:0] exp_chal;
        logic [15:0] exp_tx;
    } vec_t;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_data       = b;
        rx_data_valid = 1'b1;
        edge_cyc      = cyc_n;
        cyc(hold);
        rx_data_valid = 1'b0;
        cyc(1);
    endtask

    task automatic send_frame(input logic [31:0] d, input int hold);
        send_byte(8'hA5, hold);
        for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], hold);
    endtask

    task automatic pulse_done(input logic [15:0] r);
        core_done     = 1'b1;
        core_response = r;
        cyc(1);
        core_done     = 1'b0;
        core_response = 16'hDEAD;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (busy && n < max) begin
            cyc(1);
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    task automatic chk_tx(input string name, input logic [15:0] exp);
        logic [15:0] got;
        got = (tx_q.size() >= 2) ? {tx_q[0], tx_q[1]} : 16'hxxxx;
        chk({name, "_count"}, tx_q.size(), 2);
        chk({name, "_bytes"}, got, exp);
    endtask

    vec_t vecs[3];
    int   s0;

    initial begin
        vecs[0] = '{32'h11223344, 1, 0,  16'hBEEF, 32'h11223344, 16'hBEEF};
        vecs[1] = '{32'h11223344, 5, 3,  16'h1234, 32'h11223344, 16'h1234};
        vecs[2] = '{32'hA5A5005A, 2, 10, 16'h00FF, 32'hA5A5005A, 16'h00FF};

        reset = 1'b1; rx_data = 8'h00; rx_data_valid = 1'b0;
        core_done = 1'b0; core_response = 16'h0; tx_ready = 1'b1;
        cyc(3);
        chk("rst_chal", core_challenge, 0);
        chk("rst_start", core_start, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_txd", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_count, 0);
        reset = 1'b0;
        cyc(1);

        // Stray bytes in IDLE
        send_byte(8'h00, 1);
        chk("stray00_busy", busy, 0);
        send_byte(8'hFF, 3);
        chk("strayFF_busy", busy, 0);
        chk("stray_err", err_count, 0);
        chk("stray_start", start_cnt, 0);

        // Table-driven normal frames
        for (int v = 0; v < 3; v++) begin
            tx_q.delete();
            s0 = start_cnt;
            send_frame(vecs[v].bytes, vecs[v].hold);
            chk($sformatf("v%0d_starts", v), start_cnt - s0, 1);
            chk($sformatf("v%0d_latency", v), start_cyc - edge_cyc, 1);
            chk($sformatf("v%0d_chal", v), core_challenge, vecs[v].exp_chal);
            chk($sformatf("v%0d_wait_txv", v), tx_valid, 0);
            cyc(vecs[v].done_delay);
            pulse_done(vecs[v].resp);
            chk($sformatf("v%0d_txv_after_done", v), tx_valid, 1);
            chk($sformatf("v%0d_first_byte", v), tx_data, vecs[v].exp_tx[15:8]);
            wait_idle($sformatf("v%0d_idle", v), 20);
            chk_tx($sformatf("v%0d_tx", v), vecs[v].exp_tx);
            chk($sformatf("v%0d_err", v), err_count, exp_err);
        end

        // Byte timeout: partial frame then silence
        s0 = start_cnt;
        send_byte(8'hA5, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        cyc(c_BTO - 2);
        chk("bto_before_err", err_count, exp_err);
        chk("bto_before_busy", busy, 1);
        cyc(1);
        exp_err++;
        chk("bto_err", err_count, exp_err);
        chk("bto_idle", busy, 0);
        chk("bto_no_start", start_cnt - s0, 0);

        // Byte arriving exactly on the timeout cycle wins
        tx_q.delete();
        s0 = start_cnt;
        send_byte(8'hA5, 1);
        send_byte(8'h11, 1);
        cyc(c_BTO - 2);
        send_byte(8'h22, 1);
        chk("btie_err", err_count, exp_err);
        send_byte(8'h33, 1);
        send_byte(8'h44, 1);
        chk("btie_start", start_cnt - s0, 1);
        chk("btie_chal", core_challenge, 32'h11223344);
        pulse_done(16'hCAFE);
        wait_idle("btie_idle", 20);
        chk_tx("btie_tx", 16'hCAFE);

        // Core timeout: core_done never arrives
        tx_q.delete();
        send_frame(32'h55667788, 1);
        cyc(c_CTO - 1);
        chk("cto_before_err", err_count, exp_err);
        chk("cto_before_busy", busy, 1);
        cyc(1);
        exp_err++;
        chk("cto_err", err_count, exp_err);
        chk("cto_idle", busy, 0);
        chk("cto_no_tx", tx_q.size(), 0);

        // core_done on the timeout cycle wins
        send_frame(32'h01020304, 1);
        cyc(c_CTO - 1);
        pulse_done(16'hBEEF);
        chk("ctie_err", err_count, exp_err);
        chk("ctie_txv", tx_valid, 1);
        wait_idle("ctie_idle", 20);
        chk_tx("ctie_tx", 16'hBEEF);

        // tx backpressure with rx bytes during SEND
        tx_q.delete();
        s0 = start_cnt;
        send_frame(32'h11223344, 1);
        tx_ready = 1'b0;
        pulse_done(16'hBEEF);
        for (int i = 0; i < 100; i++) begin
            if (i == 10 || i == 40) begin rx_data = 8'hA5; rx_data_valid = 1'b1; end
            if (i == 12 || i == 42) rx_data_valid = 1'b0;
            if (i == 60) begin rx_data = 8'h11; rx_data_valid = 1'b1; end
            if (i == 61) rx_data_valid = 1'b0;
            if (i % 25 == 0) begin
                chk($sformatf("bp_txv_%0d", i), tx_valid, 1);
                chk($sformatf("bp_txd_%0d", i), tx_data, 8'hBE);
            end
            cyc(1);
        end
        chk("bp_no_accept", tx_q.size(), 0);
        tx_ready = 1'b1;
        cyc(1);
        chk("bp_second_txv", tx_valid, 1);
        chk("bp_second_txd", tx_data, 8'hEF);
        cyc(1);
        chk("bp_idle", busy, 0);
        chk_tx("bp_tx", 16'hBEEF);
        cyc(3);
        chk("bp_no_new_frame", busy, 0);
        chk("bp_starts", start_cnt - s0, 1);

        // Reset during WAIT, then a late core_done
        tx_q.delete();
        send_frame(32'hDEADBEEF, 1);
        chk("rw_chal_pre", core_challenge, 32'hDEADBEEF);
        reset = 1'b1;
        cyc(1);
        chk("rw_txv", tx_valid, 0);
        chk("rw_busy", busy, 0);
        chk("rw_chal", core_challenge, 0);
        chk("rw_err", err_count, 0);
        exp_err = 0;
        reset = 1'b0;
        pulse_done(16'h1357);
        cyc(5);
        chk("rw_no_tx", tx_q.size(), 0);
        chk("rw_idle", busy, 0);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            send_byte(8'hA5, 1);
            cyc(c_BTO - 1);
        end
        chk("sat_idle", busy, 0);
        chk("sat_err", err_count, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
